// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults for transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/baudrate_gen.sv
// rtl/baudrate_gen.sv - one-cycle tick every CLK_DIV system clocks
module baudrate_gen #(
    parameter int CLK_DIV = 218
) (
    input  logic sysclk,
    input  logic reset_n,
    output logic baud_rate_tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt              <= '0;
            baud_rate_tick_o <= 1'b0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt              <= '0;
            baud_rate_tick_o <= 1'b1;
        end else begin
            cnt              <= cnt + 1'b1;
            baud_rate_tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_top.sv
// rtl/uart_top.sv - baud generator driving the UART transmitter
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 218,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    logic baud_tick;

    baudrate_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .baud_rate_tick_o(baud_tick)
    );

    uart_tx #(
        .DATA_BITS (DATA_BITS),
        .PARITY_EN (PARITY_EN),
        .PARITY_ODD(PARITY_ODD),
        .STOP_BITS (STOP_BITS)
    ) u_tx (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .baud_rate_tick_i(baud_tick),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_o            (tx_o),
        .tx_busy_o       (tx_busy_o),
        .tx_done_o       (tx_done_o)
    );

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-entry holding register
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 baud_rate_tick_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int            CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] hold_data, shifter, shifter_next;
    logic                 hold_full, load;
    logic [CW-1:0]        bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 parity_bit, parity_next;
    logic                 tx_q, tx_next;
    logic                 done_q, done_next;

    always_comb begin
        state_next    = state;
        shifter_next  = shifter;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        parity_next   = parity_bit;
        tx_next       = tx_q;
        done_next     = 1'b0;
        load          = 1'b0;
        if (baud_rate_tick_i) begin
            case (state)
                ST_IDLE: begin
                    tx_next = 1'b1;
                    load    = hold_full;
                end
                ST_START: begin
                    tx_next      = shifter[0];
                    bit_cnt_next = '0;
                    state_next   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_next    = parity_bit;
                            state_next = ST_PARITY;
                        end else begin
                            tx_next       = 1'b1;
                            stop_cnt_next = 1'b0;
                            state_next    = ST_STOP;
                        end
                    end else begin
                        shifter_next = shifter >> 1;
                        bit_cnt_next = bit_cnt + 1'b1;
                        tx_next      = shifter[1];
                    end
                end
                ST_PARITY: begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt == LAST_STOP) begin
                        done_next = 1'b1;
                        // A pending byte starts immediately, with no idle bit in between
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
            if (load) begin
                shifter_next = hold_data;
                parity_next  = (^hold_data) ^ ODD;
                tx_next      = 1'b0;
                state_next   = ST_START;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            shifter    <= shifter_next;
            bit_cnt    <= bit_cnt_next;
            stop_cnt   <= stop_cnt_next;
            parity_bit <= parity_next;
            tx_q       <= tx_next;
            done_q     <= done_next;
        end
    end

    // Load only happens with hold_full set, so it never races an accept
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (tx_valid_i && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data_i;
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ~hold_full;
    assign tx_busy_o  = (state != ST_IDLE) || hold_full;
    assign tx_done_o  = done_q;

endmodule
